branch_predictor_gshare: RTL and testbench
==========================================

# branch_predictor_gshare

Parametrised successor to the bimodal predictor in the fetch stage. It predicts next PC from a tagged direct-mapped BTB and a gshare-indexed table of 2-bit counters, with a speculative global history register (GHR) and restore on mispredict. A self-clearing init sweep replaces the single-cycle table reset.

## Interface
- `XLEN`, default `DataBusBits` (64): address/target width.
- `BTB_IDX`, default 10: BTB index bits; 2^BTB_IDX entries.
- `BHT_IDX`, default 12: counter-table index bits.
- `GHR_LEN`, default 12: history length; must be ≤ `BHT_IDX`.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `PC` in XLEN: fetch address.
- `fetchValid` in 1: fetch advances this cycle, so the speculative GHR update is allowed.
- `PCPlus4` out XLEN: PC+4, via the shared `adder`.
- `PCPrediction` out XLEN: predicted next PC.
- `predTaken` out 1: prediction is taken.
- `predGHR` out GHR_LEN: GHR value used for this lookup; the pipeline carries it to execute.
- `ready` out 1: init sweep complete.
- `we` in 1: resolved control-flow instruction (jal, jalr, branch).
- `PCUpdate` in XLEN: resolved instruction address.
- `targetUpdate` in XLEN: resolved target.
- `takenUpdate` in 1: resolved direction.
- `isCondUpdate` in 1: 1 for a conditional branch, 0 for jal/jalr.
- `ghrUpdate` in GHR_LEN: `predGHR` captured at fetch for this instruction.
- `mispredict` in 1: resolved next PC ≠ predicted next PC.

## Operation
- BTB line layout: {valid, cond, tag = PC[XLEN-1:BTB_IDX+2], target}. BTB index = PC[BTB_IDX+1:2].
- Counter index = PC[BHT_IDX+1:2] XOR zero-extended GHR. At update, `ghrUpdate` is used in place of GHR.
- Hit = valid & tag match.
  - Hit & !cond: `predTaken`=1.
  - Hit & cond: `predTaken` = counter[1].
  - Miss: `predTaken`=0.
- `PCPrediction` = `predTaken` ? target : `PCPlus4`.
- Speculative GHR: when `fetchValid` & hit & cond & `ready`, GHR ← {GHR[GHR_LEN-2:0], `predTaken`}.
- Recovery on `we` & `mispredict`:
  - Conditional: GHR ← {`ghrUpdate`[GHR_LEN-2:0], `takenUpdate`}.
  - Otherwise: GHR ← `ghrUpdate`.
  - Recovery overrides any same-cycle speculative shift.
- Table update on `we`:
  - If `takenUpdate`, write the BTB line {1, `isCondUpdate`, tag, `targetUpdate`}.
  - If `isCondUpdate`, saturating counter update: 00↔01↔10↔11. Increment on taken, decrement on not-taken, saturate at both ends.
- Init FSM, states INIT → READY:
  - `reset_n` low: state INIT, sweep counter 0, GHR 0.
  - In INIT, each cycle clears BTB valid at index cnt and sets the counter at cnt to 2'b11. cnt runs to 2^max(BTB_IDX,BHT_IDX)-1; indices beyond a table's depth are ignored.
  - After the last index, go to READY. READY holds until reset.
- While not READY: `ready`=0, `predTaken`=0, `PCPrediction`=`PCPlus4`, `we` ignored, GHR frozen at 0.
- Reset asserted mid-sweep or mid-operation restarts the sweep from index 0.

## Timing
- Lookup is combinational from `PC` and the current GHR; zero-cycle latency.
- GHR, FSM and table writes take effect on the rising edge. A write in cycle n is visible to a lookup in cycle n+1.
- Reset values: `ready`=0, `predTaken`=0, `predGHR`=0, `PCPrediction`=`PCPlus4`.
- The sweep takes 2^max(BTB_IDX,BHT_IDX) cycles; `ready` rises the cycle after the last index is written.
- Update and lookup to the same index in one cycle: the lookup sees old contents.
- Sweep counter and index arithmetic are unsigned and wrap-free. The final index is compared explicitly.

## Configuration
- `BP_GSHARE_EN` defined: gshare indexing and GHR as above.
- `BP_GSHARE_EN` undefined:
  - Counter index = PC[BHT_IDX+1:2] (pure bimodal).
  - GHR logic is removed.
  - `predGHR` is tied to 0 and `ghrUpdate` is ignored.
  - BTB, counters and init FSM are unchanged.

## Structure
- Shared package `diagv2_bp_pkg`: counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the init-state enum. Width parameters stay on the module.
- Sub-module `bp_sat_counter`: combinational 2-bit saturating next-state function (counter, taken → next).
- PC+4 reuses the existing `adder`.

## Test plan
Bench uses BTB_IDX=BHT_IDX=GHR_LEN=4, with `BP_GSHARE_EN` defined.
- Reset, then release → `ready`=0 for 16 cycles, then 1. During the sweep, PC=0x100 → `PCPrediction`=0x104.
- Update with PCUpdate=0x40, target 0x80, taken, isCond=0 → next cycle PC=0x40 gives `PCPrediction`=0x80 and `predTaken`=1. GHR is unchanged by the fetch.
- Conditional branch at 0x40 to 0x20, updated not-taken twice with ghrUpdate=0 → PC=0x40 with GHR=0 predicts 0x44.
- Fetch two conditional hits predicted taken → `predGHR` goes 0000 → 0001 → 0011. A mispredict with ghrUpdate=0001, takenUpdate=0 → GHR=0010 next cycle.
- Same-cycle speculative shift and mispredict recovery → the recovery value wins.
- Assert `reset_n` low at sweep index 7 → the sweep restarts. `ready` rises only after a full 16 further cycles.

Source files
------------

// File: rtl/diagv2_bp_pkg.sv
// Shared definitions for the fetch-stage branch predictors: 2-bit counter
// encodings, init-sweep states and the default address width.
package diagv2_bp_pkg;

    localparam int DataBusBits = 64;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

endpackage

// File: rtl/adder.sv
// Plain unsigned adder shared by fetch-stage address arithmetic.
module adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
    import diagv2_bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cnt;
        case (ctr_e'(cnt))
            CTR_SNT: next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  next = taken ? CTR_ST  : CTR_WNT;
            default: next = taken ? CTR_ST  : CTR_WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Next-PC predictor: tagged direct-mapped BTB plus 2-bit counter table with an init sweep.
// Define BP_GSHARE_EN for gshare indexing with a speculative GHR; otherwise pure bimodal.
module branch_predictor_gshare
    import diagv2_bp_pkg::*;
#(
    parameter int XLEN    = DataBusBits,
    parameter int BTB_IDX = 10,
    parameter int BHT_IDX = 12,
    parameter int GHR_LEN = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [XLEN-1:0]    PC,
    input  logic               fetchValid,
    output logic [XLEN-1:0]    PCPlus4,
    output logic [XLEN-1:0]    PCPrediction,
    output logic               predTaken,
    output logic [GHR_LEN-1:0] predGHR,
    output logic               ready,
    input  logic               we,
    input  logic [XLEN-1:0]    PCUpdate,
    input  logic [XLEN-1:0]    targetUpdate,
    input  logic               takenUpdate,
    input  logic               isCondUpdate,
    input  logic [GHR_LEN-1:0] ghrUpdate,
    input  logic               mispredict
);

    localparam int TAG_W     = XLEN - BTB_IDX - 2;
    localparam int SWEEP_W   = (BTB_IDX > BHT_IDX) ? BTB_IDX : BHT_IDX;
    localparam int BTB_DEPTH = 1 << BTB_IDX;
    localparam int BHT_DEPTH = 1 << BHT_IDX;
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = '1;

    logic             btb_valid  [BTB_DEPTH];
    logic             btb_cond   [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [XLEN-1:0]  btb_target [BTB_DEPTH];
    logic [1:0]       bht        [BHT_DEPTH];

    init_state_e        state;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               ready_q;

    logic [BTB_IDX-1:0] btb_rd_idx;
    logic [BTB_IDX-1:0] btb_wr_idx;
    logic [BHT_IDX-1:0] bht_rd_idx;
    logic [BHT_IDX-1:0] bht_wr_idx;
    logic [BHT_IDX-1:0] lookup_hist;
    logic [BHT_IDX-1:0] update_hist;
    logic               hit;
    logic               hit_cond;
    logic [1:0]         ctr_next;
    logic               sweep_in_btb;
    logic               sweep_in_bht;
    logic               unused_bits;

    adder #(.WIDTH(XLEN)) u_pc_plus4 (
        .a   (PC),
        .b   (XLEN'(4)),
        .sum (PCPlus4)
    );

    assign btb_rd_idx = PC[BTB_IDX+1:2];
    assign btb_wr_idx = PCUpdate[BTB_IDX+1:2];
    assign bht_rd_idx = PC[BHT_IDX+1:2] ^ lookup_hist;
    assign bht_wr_idx = PCUpdate[BHT_IDX+1:2] ^ update_hist;

    assign hit      = btb_valid[btb_rd_idx] && (btb_tag[btb_rd_idx] == PC[XLEN-1:BTB_IDX+2]);
    assign hit_cond = hit && btb_cond[btb_rd_idx];

    assign ready        = ready_q;
    assign predTaken    = ready_q && hit && (!btb_cond[btb_rd_idx] || bht[bht_rd_idx][1]);
    assign PCPrediction = predTaken ? btb_target[btb_rd_idx] : PCPlus4;

    bp_sat_counter u_sat (
        .cnt   (bht[bht_wr_idx]),
        .taken (takenUpdate),
        .next  (ctr_next)
    );

    // The sweep walks the larger table; indices past the smaller one are skipped.
    assign sweep_in_btb = (32'(sweep_cnt) < 32'(BTB_DEPTH));
    assign sweep_in_bht = (32'(sweep_cnt) < 32'(BHT_DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            ready_q   <= 1'b0;
        end else if (state == INIT) begin
            if (sweep_cnt == SWEEP_LAST) begin
                state   <= READY;
                ready_q <= 1'b1;
            end else begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            if (sweep_in_btb) btb_valid[sweep_cnt[BTB_IDX-1:0]] <= 1'b0;
            if (sweep_in_bht) bht[sweep_cnt[BHT_IDX-1:0]] <= CTR_ST;
        end else if (we) begin
            if (takenUpdate) begin
                btb_valid[btb_wr_idx]  <= 1'b1;
                btb_cond[btb_wr_idx]   <= isCondUpdate;
                btb_tag[btb_wr_idx]    <= PCUpdate[XLEN-1:BTB_IDX+2];
                btb_target[btb_wr_idx] <= targetUpdate;
            end
            if (isCondUpdate) bht[bht_wr_idx] <= ctr_next;
        end
    end

`ifdef BP_GSHARE_EN
    logic [GHR_LEN-1:0] ghr;

    assign lookup_hist = BHT_IDX'(ghr);
    assign update_hist = BHT_IDX'(ghrUpdate);
    assign predGHR     = ghr;
    assign unused_bits = ^{PCUpdate[1:0]};

    // Mispredict recovery takes priority over the speculative shift of the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr <= '0;
        end else if (state == READY) begin
            if (we && mispredict) begin
                ghr <= isCondUpdate ? GHR_LEN'({ghrUpdate, takenUpdate}) : ghrUpdate;
            end else if (fetchValid && hit_cond) begin
                ghr <= GHR_LEN'({ghr, predTaken});
            end
        end
    end
`else
    assign lookup_hist = '0;
    assign update_hist = '0;
    assign predGHR     = '0;
    assign unused_bits = ^{PCUpdate[1:0], fetchValid, mispredict, ghrUpdate, hit_cond};
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare with a per-cycle reference model;
// follows BP_GSHARE_EN so the model matches the build under test.
module tb_branch_predictor_gshare;

`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] PC = 32'h100;
    logic        fetchValid = 1'b0;
    logic [31:0] PCPlus4;
    logic [31:0] PCPrediction;
    logic        predTaken;
    logic [3:0]  predGHR;
    logic        ready;
    logic        we = 1'b0;
    logic [31:0] PCUpdate = '0;
    logic [31:0] targetUpdate = '0;
    logic        takenUpdate = 1'b0;
    logic        isCondUpdate = 1'b0;
    logic [3:0]  ghrUpdate = '0;
    logic        mispredict = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    branch_predictor_gshare #(
        .XLEN(32), .BTB_IDX(4), .BHT_IDX(4), .GHR_LEN(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .PC           (PC),
        .fetchValid   (fetchValid),
        .PCPlus4      (PCPlus4),
        .PCPrediction (PCPrediction),
        .predTaken    (predTaken),
        .predGHR      (predGHR),
        .ready        (ready),
        .we           (we),
        .PCUpdate     (PCUpdate),
        .targetUpdate (targetUpdate),
        .takenUpdate  (takenUpdate),
        .isCondUpdate (isCondUpdate),
        .ghrUpdate    (ghrUpdate),
        .mispredict   (mispredict)
    );

    always #5 clk = ~clk;

    // Reference model: 16-entry BTB and counter table, counters held as 0..3.
    bit          m_valid [16];
    bit          m_cond  [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_ready = 1'b0;
    int          m_sweep = 0;
    int          m_ghr = 0;

    function automatic int bt_idx(logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[bt_idx(pc)] && (m_tag[bt_idx(pc)] == (pc >> 6));
    endfunction

    function automatic bit m_taken(logic [31:0] pc);
        int bi;
        bi = bt_idx(pc) ^ (GSHARE ? m_ghr : 0);
        return m_ready && m_hit(pc) && (!m_cond[bt_idx(pc)] || m_ctr[bi] >= 2);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready <= 1'b0;
            m_sweep <= 0;
            m_ghr   <= 0;
        end else if (!m_ready) begin
            m_valid[m_sweep] <= 1'b0;
            m_ctr[m_sweep]   <= 3;
            if (m_sweep == 15) m_ready <= 1'b1;
            else m_sweep <= m_sweep + 1;
        end else begin
            if (we && takenUpdate) begin
                m_valid[bt_idx(PCUpdate)] <= 1'b1;
                m_cond[bt_idx(PCUpdate)]  <= isCondUpdate;
                m_tag[bt_idx(PCUpdate)]   <= PCUpdate >> 6;
                m_tgt[bt_idx(PCUpdate)]   <= targetUpdate;
            end
            if (we && isCondUpdate) begin
                int ui;
                ui = bt_idx(PCUpdate) ^ (GSHARE ? int'(ghrUpdate) : 0);
                m_ctr[ui] <= takenUpdate ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                                         : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
            end
            if (we && mispredict)
                m_ghr <= isCondUpdate ? (((int'(ghrUpdate) << 1) | int'(takenUpdate)) & 15)
                                      : int'(ghrUpdate);
            else if (fetchValid && m_hit(PC) && m_cond[bt_idx(PC)])
                m_ghr <= ((m_ghr << 1) | int'(m_taken(PC))) & 15;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        bit et;
        et = m_taken(PC);
        check("m_ready", {31'd0, ready}, {31'd0, m_ready});
        check("m_predTaken", {31'd0, predTaken}, {31'd0, et});
        check("m_PCPrediction", PCPrediction, et ? m_tgt[bt_idx(PC)] : PC + 32'd4);
        check("m_predGHR", {28'd0, predGHR}, GSHARE ? 32'(m_ghr) : 32'd0);
        check("m_PCPlus4", PCPlus4, PC + 32'd4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(logic [31:0] pcu, logic [31:0] tgt, bit tk, bit cnd,
                       logic [3:0] gh, bit mp);
        we = 1'b1; PCUpdate = pcu; targetUpdate = tgt; takenUpdate = tk;
        isCondUpdate = cnd; ghrUpdate = gh; mispredict = mp;
    endtask

    logic [31:0] pcs [6] = '{32'h40, 32'h48, 32'h4C, 32'h104C, 32'h48, 32'h48};

    initial begin
        repeat (3) step();
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_predGHR", {28'd0, predGHR}, 32'd0);
        check("reset_pred", PCPrediction, 32'h104);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("sweep_ready", {31'd0, ready}, 32'd0);
            check("sweep_pred", PCPrediction, 32'h104);
            step();
        end
        @(negedge clk);
        check("ready_after_sweep", {31'd0, ready}, 32'd1);
        step();

        // Unconditional jump 0x40 -> 0x80.
        upd(32'h40, 32'h80, 1'b1, 1'b0, 4'h0, 1'b1);
        step();
        we = 1'b0; mispredict = 1'b0; PC = 32'h40; fetchValid = 1'b1;
        @(negedge clk);
        check("jal_pred", PCPrediction, 32'h80);
        check("jal_taken", {31'd0, predTaken}, 32'd1);
        check("jal_ghr", {28'd0, predGHR}, 32'd0);
        step();
        fetchValid = 1'b0;
        @(negedge clk);
        check("jal_ghr_after", {28'd0, predGHR}, 32'd0);
        step();

        // Conditional 0x40 -> 0x20: taken once, then not-taken twice (3 -> 3 -> 2 -> 1).
        upd(32'h40, 32'h20, 1'b1, 1'b1, 4'h0, 1'b0);
        step();
        takenUpdate = 1'b0;
        step();
        step();
        we = 1'b0;
        @(negedge clk);
        check("cond_nt_pred", PCPrediction, 32'h44);
        check("cond_nt_taken", {31'd0, predTaken}, 32'd0);
        step();

        // Two speculative taken fetches at 0x48, then a conditional mispredict.
        upd(32'h48, 32'h200, 1'b1, 1'b1, 4'h0, 1'b0);
        step();
        we = 1'b0; PC = 32'h48; fetchValid = 1'b1;
        @(negedge clk);
        check("spec0_ghr", {28'd0, predGHR}, 32'd0);
        check("spec0_pred", PCPrediction, 32'h200);
        step();
        @(negedge clk);
        check("spec1_ghr", {28'd0, predGHR}, GSHARE ? 32'd1 : 32'd0);
        check("spec1_pred", PCPrediction, 32'h200);
        step();
        fetchValid = 1'b0;
        @(negedge clk);
        check("spec2_ghr", {28'd0, predGHR}, GSHARE ? 32'd3 : 32'd0);
        step();
        upd(32'h48, 32'h200, 1'b0, 1'b1, 4'b0001, 1'b1);
        step();
        we = 1'b0; mispredict = 1'b0;
        @(negedge clk);
        check("recover_cond_ghr", {28'd0, predGHR}, GSHARE ? 32'd2 : 32'd0);
        step();

        // Speculative shift and unconditional recovery in the same cycle.
        upd(32'h40, 32'h20, 1'b1, 1'b0, 4'b1001, 1'b1);
        PC = 32'h48; fetchValid = 1'b1;
        @(negedge clk);
        check("race_pred", PCPrediction, GSHARE ? 32'h4C : 32'h200);
        step();
        we = 1'b0; mispredict = 1'b0; fetchValid = 1'b0;
        @(negedge clk);
        check("race_ghr", {28'd0, predGHR}, GSHARE ? 32'd9 : 32'd0);
        step();

        // Write and lookup of the same index in one cycle: lookup sees old contents.
        upd(32'h4C, 32'h300, 1'b1, 1'b0, 4'h0, 1'b0);
        PC = 32'h4C;
        @(negedge clk);
        check("same_idx_old", PCPrediction, 32'h50);
        step();
        we = 1'b0;
        @(negedge clk);
        check("same_idx_new", PCPrediction, 32'h300);
        step();
        PC = 32'h104C;
        @(negedge clk);
        check("tag_miss", PCPrediction, 32'h1050);
        step();

        // Drive the 0x48 counter into the low saturation end, then mixed fetches.
        for (int k = 0; k < 4; k++) begin
            upd(32'h48, 32'h200, 1'b0, 1'b1, 4'h0, 1'b0);
            step();
        end
        we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            PC = pcs[k];
            fetchValid = (k % 2 == 0);
            step();
        end
        fetchValid = 1'b0;

        // Reset at sweep index 7 restarts the full sweep.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (7) step();
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_ready", {31'd0, ready}, 32'd0);
        check("midreset_ghr", {28'd0, predGHR}, 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("resweep_ready", {31'd0, ready}, 32'd0);
            step();
        end
        @(negedge clk);
        check("resweep_done", {31'd0, ready}, 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
